adc_trigger: RTL

- Digital trigger detector between the registered ADC input buffer and adc_driver; replaces the push-button as adc_driver's trigger_req source.
- Watches the selected ADC channel at the sample rate, applies level, slope and hysteresis qualification, post-arm holdoff and optional auto-trigger timeout.
- Emits a one-clock trigger_req pulse to adc_driver.
- Configuration comes from a 32-bit SPI config word.

---
 rtl/adc_trigger.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/adc_trigger.sv
// Digital ADC trigger: level/slope/hysteresis qualification, post-arm holdoff, optional auto timeout.
// trigger_req pulses one clock after the qualifying strobe edge; no backpressure, evaluation only on sample_en.
module adc_trigger #(
    parameter int          HOLDOFF_W    = 16,
    parameter int          AUTO_W       = 16,
    parameter int unsigned AUTO_TIMEOUT = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic [7:0]  adc_a,
    input  logic [7:0]  adc_b,
    input  logic [31:0] trig_cfg,
    input  logic        arm,
    output logic        trigger_req,
    output logic        armed,
    output logic        auto_fired
);

    typedef enum logic [2:0] {
        IDLE,
        HOLDOFF,
        ARMING,
        WAIT_CROSS,
        FIRED
    } state_t;

    state_t                state, state_n;
    logic                  arm_q;
    logic                  arm_rise;

    logic [7:0]            level_r;
    logic [3:0]            hyst_r;
    logic                  src_r;
    logic                  slope_r;
    logic                  auto_en_r;
    logic [HOLDOFF_W-1:0]  holdoff_r;

    logic [HOLDOFF_W-1:0]  hold_cnt, hold_cnt_n;
    logic [AUTO_W-1:0]     auto_cnt, auto_cnt_n;
    logic [AUTO_W-1:0]     auto_inc;

    logic                  latch_cfg;
    logic                  fire;
    logic                  fire_auto;

    logic [8:0]            lo_diff;
    logic [8:0]            hi_sum;
    logic [7:0]            lo;
    logic [7:0]            hi;
    logic [7:0]            sample;
    logic                  precond;
    logic                  crossed;
    logic                  timeout;
    logic                  cfg_unused;

    assign cfg_unused = trig_cfg[15];
    assign arm_rise   = arm && !arm_q;

    // Thresholds in 9 bits so under/overflow saturates instead of wrapping.
    assign lo_diff = {1'b0, level_r} - {5'b0, hyst_r};
    assign hi_sum  = {1'b0, level_r} + {5'b0, hyst_r};
    assign lo      = lo_diff[8] ? 8'd0 : lo_diff[7:0];
    assign hi      = hi_sum[8] ? 8'hFF : hi_sum[7:0];

    assign sample  = src_r ? adc_b : adc_a;
    assign precond = slope_r ? (sample >= hi) : (sample <= lo);
    assign crossed = slope_r ? (sample <= level_r) : (sample >= level_r);

    assign auto_inc = (&auto_cnt) ? auto_cnt : auto_cnt + AUTO_W'(1);
    assign timeout  = auto_en_r && (auto_inc == AUTO_W'(AUTO_TIMEOUT));

    assign armed = (state == ARMING) || (state == WAIT_CROSS);

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        auto_cnt_n = auto_cnt;
        latch_cfg  = 1'b0;
        fire       = 1'b0;
        fire_auto  = 1'b0;
        case (state)
            IDLE: begin
                // A strobe coincident with the arm rise is deliberately ignored.
                if (arm_rise) begin
                    latch_cfg  = 1'b1;
                    hold_cnt_n = '0;
                    auto_cnt_n = '0;
                    state_n    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!arm) begin
                    state_n = IDLE;
                end else if (hold_cnt == holdoff_r) begin
                    state_n = ARMING;
                end else if (sample_en) begin
                    hold_cnt_n = hold_cnt + HOLDOFF_W'(1);
                end
            end
            ARMING, WAIT_CROSS: begin
                if (!arm) begin
                    state_n = IDLE;
                end else if (sample_en) begin
                    if (auto_en_r) begin
                        auto_cnt_n = auto_inc;
                    end
                    // A real crossing outranks the timeout on the same strobe.
                    if ((state == WAIT_CROSS) && crossed) begin
                        state_n = FIRED;
                        fire    = 1'b1;
                    end else if (timeout) begin
                        state_n   = FIRED;
                        fire      = 1'b1;
                        fire_auto = 1'b1;
                    end else if ((state == ARMING) && precond) begin
                        state_n = WAIT_CROSS;
                    end
                end
            end
            FIRED: begin
                if (!arm) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // arm_q resets high so an arm level already high out of reset is not taken as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            arm_q       <= 1'b1;
            hold_cnt    <= '0;
            auto_cnt    <= '0;
            trigger_req <= 1'b0;
            auto_fired  <= 1'b0;
        end else begin
            state       <= state_n;
            arm_q       <= arm;
            hold_cnt    <= hold_cnt_n;
            auto_cnt    <= auto_cnt_n;
            trigger_req <= fire;
            if (latch_cfg) begin
                auto_fired <= 1'b0;
            end else if (fire) begin
                auto_fired <= fire_auto;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r   <= '0;
            hyst_r    <= '0;
            src_r     <= 1'b0;
            slope_r   <= 1'b0;
            auto_en_r <= 1'b0;
            holdoff_r <= '0;
        end else if (latch_cfg) begin
            level_r   <= trig_cfg[7:0];
            hyst_r    <= trig_cfg[11:8];
            src_r     <= trig_cfg[12];
            slope_r   <= trig_cfg[13];
            auto_en_r <= trig_cfg[14];
            holdoff_r <= HOLDOFF_W'(trig_cfg[31:16]);
        end
    end

    a_req_only_in_fired: assert property (@(posedge clk) disable iff (rst)
        trigger_req |-> (state == FIRED));

endmodule
